rng_arbiter: RTL and testbench

Shared-access controller for the 32-bit XNOR LFSR random source (taps 31, 29, 25, 24) in the wallet firmware. It arbitrates round-robin between N_REQ requesters, such as the key-generation, nonce and padding blocks. It gates the LFSR so every delivered byte is built from 8 fresh shifts, and streams a BURST_LEN-byte burst to the granted requester over a valid/ready handshake. It also owns seed loading and prevents the LFSR from entering its lock-up state.

---
 rtl/rng_arbiter_pkg.sv | 19 +
 rtl/rng_lfsr32.sv | 33 +++
 rtl/rng_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rng_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_arbiter_pkg.sv
// Shared types and constants for the random-source arbiter and its LFSR.
package rng_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPIN  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  localparam int LFSR_WIDTH  = 32;
  localparam int SPIN_CYCLES = 8;
  localparam logic [LFSR_WIDTH-1:0] LFSR_LOCKUP = 32'hFFFF_FFFF;

  // XNOR Fibonacci step, taps 31/29/25/24; all-ones is the only fixed point.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
    return {v[LFSR_WIDTH-2:0], ~(v[31] ^ v[29] ^ v[25] ^ v[24])};
  endfunction

endpackage

// File: rtl/rng_lfsr32.sv
// 32-bit XNOR LFSR with a load port that takes priority over shifting.
module rng_lfsr32
  import rng_arbiter_pkg::*;
#(
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2345
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_shift_en,
  input  logic        i_load,
  input  logic [31:0] i_load_value,
  output logic [31:0] o_value
);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_load) begin
      lfsr_d = i_load_value;
    end else if (i_shift_en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) lfsr_q <= SEED_DEFAULT;
    else            lfsr_q <= lfsr_d;
  end

  assign o_value = lfsr_q;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter streaming LFSR bytes (8 fresh shifts each) to one requester per burst.
// state | meaning
// IDLE  | no grant; seed loads accepted here, else arbitrate
// SPIN  | LFSR shifting, 8 cycles per byte
// VALID | byte presented, LFSR frozen until handshake
module rng_arbiter
  import rng_arbiter_pkg::*;
#(
  parameter int          N_REQ        = 4,
  parameter int          BURST_LEN    = 32,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2345
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [31:0]      i_seed,
  input  logic             i_seed_valid,
  output logic             o_seed_ack,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic             o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [2:0]         spin_q, spin_d;
  logic               seed_ack_q, seed_ack_d;

  logic               lfsr_shift, lfsr_load;
  logic [31:0]        lfsr_load_value, lfsr_val;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic               held, last_byte;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
    logic [IDX_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= (IDX_W+1)'(N_REQ)) s = s - (IDX_W+1)'(N_REQ);
    return s[IDX_W-1:0];
  endfunction

  rng_lfsr32 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_shift_en   (lfsr_shift),
    .i_load       (lfsr_load),
    .i_load_value (lfsr_load_value),
    .o_value      (lfsr_val)
  );

  // Rotate so bit k is requester (ptr+k); scanning high-to-low leaves the nearest winner.
  always_comb begin
    req_dbl = {i_req, i_req} >> ptr_q;
    req_rot = req_dbl[N_REQ-1:0];
    found   = 1'b0;
    win_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found   = 1'b1;
        win_idx = wrap_add(ptr_q, IDX_W'(k));
      end
    end
  end

  assign held      = |(i_req & gnt_q);
  assign last_byte = (cnt_q == 8'(BURST_LEN-1));

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_idx_d       = gnt_idx_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    spin_d          = spin_q;
    seed_ack_d      = 1'b0;
    lfsr_shift      = 1'b0;
    lfsr_load       = 1'b0;
    lfsr_load_value = i_seed;

    case (state_q)
      ST_IDLE: begin
        if (i_seed_valid) begin
          lfsr_load       = 1'b1;
          lfsr_load_value = (i_seed == LFSR_LOCKUP) ? SEED_DEFAULT : i_seed;
          seed_ack_d      = 1'b1;
        end else if (found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          gnt_idx_d      = win_idx;
          cnt_d          = '0;
          spin_d         = '0;
          state_d        = ST_SPIN;
        end
      end
      ST_SPIN: begin
        lfsr_shift = 1'b1;
        if (!held) begin
          gnt_d   = '0;
          ptr_d   = wrap_add(gnt_idx_q, IDX_W'(1));
          state_d = ST_IDLE;
        end else if (spin_q == 3'(SPIN_CYCLES-1)) begin
          state_d = ST_VALID;
        end else begin
          spin_d = spin_q + 3'd1;
        end
      end
      ST_VALID: begin
        if (i_ready) cnt_d = cnt_q + 8'd1;
        if (!held || (i_ready && last_byte)) begin
          gnt_d   = '0;
          ptr_d   = wrap_add(gnt_idx_q, IDX_W'(1));
          state_d = ST_IDLE;
        end else if (i_ready) begin
          spin_d  = '0;
          state_d = ST_SPIN;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      spin_q     <= '0;
      seed_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      spin_q     <= spin_d;
      seed_ack_q <= seed_ack_d;
    end
  end

  assign o_seed_ack = seed_ack_q;
  assign o_gnt      = gnt_q;
  assign o_data     = lfsr_val[7:0];
  assign o_valid    = (state_q == ST_VALID);
  assign o_last     = o_valid && last_byte;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rng_arbiter;

  localparam int          NR    = 4;
  localparam int          BL    = 32;
  localparam logic [31:0] SDEF  = 32'hACE1_2345;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seed;
  logic        seed_valid;
  logic        seed_ack;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // model: owner<0 means idle; shifts==8 means a byte is being offered
  logic [31:0] m_lfsr;
  int          m_owner, m_shifts, m_cnt, m_ptr;
  bit          m_ack;

  rng_arbiter #(.N_REQ(NR), .BURST_LEN(BL), .SEED_DEFAULT(SDEF)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_seed       (seed),
    .i_seed_valid (seed_valid),
    .o_seed_ack   (seed_ack),
    .i_req        (req),
    .o_gnt        (gnt),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_last       (last),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] poly_step(input logic [31:0] v);
    return {v[30:0], ~(v[31] ^ v[29] ^ v[25] ^ v[24])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SDEF; m_owner = -1; m_shifts = 0; m_cnt = 0; m_ptr = 0; m_ack = 0;
  endtask

  task automatic end_burst();
    m_ptr   = (m_owner + 1) % NR;
    m_owner = -1;
  endtask

  task automatic step_model();
    bit won;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_ack = 0;
    if (m_owner < 0) begin
      if (seed_valid) begin
        m_lfsr = (seed == 32'hFFFF_FFFF) ? SDEF : seed;
        m_ack  = 1;
      end else begin
        won = 0;
        for (int k = 0; k < NR; k++) begin
          if (!won && req[(m_ptr + k) % NR]) begin
            won = 1; m_owner = (m_ptr + k) % NR; m_shifts = 0; m_cnt = 0;
          end
        end
      end
    end else if (m_shifts < 8) begin
      m_lfsr = poly_step(m_lfsr);
      if (!req[m_owner]) end_burst();
      else m_shifts++;
    end else begin
      if (ready) m_cnt++;
      if (!req[m_owner] || (ready && m_cnt == BL)) end_burst();
      else if (ready) m_shifts = 0;
    end
  endtask

  task automatic compare_model();
    logic [3:0] e_gnt;
    bit         e_valid;
    e_gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e_valid = (m_owner >= 0) && (m_shifts == 8);
    chk("gnt",   32'(gnt),   32'(e_gnt));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("last",  32'(last),  32'(e_valid && (m_cnt == BL-1)));
    chk("busy",  32'(busy),  32'(m_owner >= 0));
    chk("ack",   32'(seed_ack), 32'(m_ack));
    chk("data",  32'(data),  32'(m_lfsr[7:0]));
    chk("lfsr",  dut.lfsr_val, m_lfsr);
  endtask

  // One clock: compare mid-cycle, advance model, return just after the edge.
  task automatic cyc();
    @(negedge clk);
    compare_model();
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!valid && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_valid", 32'(valid), 32'd1);
  endtask

  task automatic run_burst(output int nbytes, output int nlast, output int last_pos);
    bit done;
    int n;
    done = 0; nbytes = 0; nlast = 0; last_pos = -1; n = 0;
    while (!done && n < 600) begin
      if (valid && ready) begin
        nbytes++;
        if (last) begin
          nlast++;
          last_pos = nbytes;
          done = 1;
        end
      end
      cyc();
      n++;
    end
    chk("burst_done", 32'(done), 32'd1);
  endtask

  initial begin
    int n, nb, nl, lp, hs;
    logic [7:0]  d0;
    logic [31:0] l0;

    rst_n = 0; seed = 0; seed_valid = 0; req = 0; ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_data",  32'(data),  32'h45);
    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_lfsr",  dut.lfsr_val, SDEF);
    rst_n = 1;
    cyc();

    // seed 1, single requester, full burst
    seed = 32'h0000_0001; seed_valid = 1;
    cyc();
    chk("seed1_ack", 32'(seed_ack), 32'd1);
    chk("seed1_lfsr", dut.lfsr_val, 32'h0000_0001);
    seed_valid = 0;
    req = 4'b0001; ready = 1;
    cyc();
    chk("s1_gnt", 32'(gnt), 32'b0001);
    chk("s1_ack_pulse", 32'(seed_ack), 32'd0);
    wait_valid(20, n);
    chk("s1_latency", 32'(n + 1), 32'd9);
    chk("s1_first_data", 32'(data), 32'hFF);
    chk("s1_first_lfsr", dut.lfsr_val, 32'h0000_01FF);
    run_burst(nb, nl, lp);
    chk("s1_bytes", 32'(nb), 32'd32);
    chk("s1_nlast", 32'(nl), 32'd1);
    chk("s1_lastpos", 32'(lp), 32'd32);
    chk("s1_gnt_drop", 32'(gnt), 32'd0);

    // reset while a byte is being offered
    cyc();
    wait_valid(20, n);
    rst_n = 0;
    cyc();
    chk("rv_valid", 32'(valid), 32'd0);
    chk("rv_gnt", 32'(gnt), 32'd0);
    chk("rv_lfsr", dut.lfsr_val, SDEF);
    rst_n = 1;
    req = 4'b1111;

    // three round-robin bursts
    cyc();
    chk("rr_gnt0", 32'(gnt), 32'b0001);
    run_burst(nb, nl, lp);
    chk("rr_gap0", 32'(gnt), 32'd0);
    cyc();
    chk("rr_gnt1", 32'(gnt), 32'b0010);
    run_burst(nb, nl, lp);
    chk("rr_gap1", 32'(gnt), 32'd0);
    cyc();
    chk("rr_gnt2", 32'(gnt), 32'b0100);
    run_burst(nb, nl, lp);
    req = 4'b0000;
    chk("rr_end_gnt", 32'(gnt), 32'd0);
    cyc();

    // lock-up seed substitution
    seed = 32'hFFFF_FFFF; seed_valid = 1;
    cyc();
    seed_valid = 0;
    chk("lock_ack", 32'(seed_ack), 32'd1);
    chk("lock_lfsr", dut.lfsr_val, 32'hACE1_2345);

    // seed request during SPIN waits for IDLE
    req = 4'b1000;
    cyc();
    chk("sp_gnt", 32'(gnt), 32'b1000);
    cyc();
    seed = 32'h1234_5678; seed_valid = 1;
    repeat (3) cyc();
    req = 4'b0000;
    n = 0;
    while (!seed_ack && n < 20) begin
      cyc();
      n++;
    end
    chk("sp_ack_seen", 32'(seed_ack), 32'd1);
    chk("sp_ack_delay", 32'(n), 32'd2);
    chk("sp_lfsr", dut.lfsr_val, 32'h1234_5678);
    seed_valid = 0;
    cyc();

    // backpressure: byte and LFSR frozen while not ready
    req = 4'b0001; ready = 0;
    cyc();
    wait_valid(20, n);
    d0 = data; l0 = dut.lfsr_val;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("bp_data", 32'(data), 32'(d0));
      chk("bp_lfsr", dut.lfsr_val, l0);
    end
    ready = 1;
    cyc();
    chk("bp_delivered", 32'(valid), 32'd0);
    req = 4'b0000;
    cyc();
    chk("bp_abort_busy", 32'(busy), 32'd0);

    // drop req[1] during SPIN of byte 5; req[2] pending
    req = 4'b0110; ready = 1;
    cyc();
    chk("dr_gnt", 32'(gnt), 32'b0010);
    hs = 0; n = 0;
    while (hs < 4 && n < 200) begin
      if (valid && ready) hs++;
      cyc();
      n++;
    end
    chk("dr_hs", 32'(hs), 32'd4);
    cyc(); cyc();
    req = 4'b0100;
    cyc();
    chk("dr_gnt_off", 32'(gnt), 32'd0);
    chk("dr_ptr", 32'(dut.ptr_q), 32'd2);
    cyc();
    chk("dr_gnt2", 32'(gnt), 32'b0100);
    req = 4'b0000;
    cyc(); cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      ready = ($urandom_range(0, 3) != 0);
      if (!seed_valid && $urandom_range(0, 99) == 0) begin
        seed_valid = 1;
        seed = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      rst_n = ($urandom_range(0, 1499) != 0);
      cyc();
      if (seed_ack || !rst_n) seed_valid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
